// File: rtl/iq_frame_serializer.sv
// Serializes snapshots of the four 2-bit radio sample channels into fixed-length frames.
// Each frame is a sync header byte followed by FRAME_SAMPLES payload words, sent MSB-first.
module iq_frame_serializer #(
  parameter int          FRAME_SAMPLES = 16,
  parameter logic [7:0]  SYNC_WORD     = 8'hA5
) (
  input  logic       DATA_CLK,
  input  logic       RST,
  input  logic [1:0] R1_I,
  input  logic [1:0] R1_Q,
  input  logic [1:0] R0_I,
  input  logic [1:0] R0_Q,
  input  logic       ENABLE,
  input  logic       TEST_MODE,
  output logic       DATA_OUT,
  output logic       SYNC,
  output logic       MISC
);

  localparam int             WCW       = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t         state_reg,    state_next;
  logic [2:0]     bit_cnt_reg,  bit_cnt_next;
  logic [WCW-1:0] word_cnt_reg, word_cnt_next;
  logic [7:0]     test_cnt_reg, test_cnt_next;
  logic [7:0]     shift_reg,    shift_next;
  logic [7:0]     in_q_reg;
  logic           data_out_reg, data_out_next;
  logic           sync_reg,     sync_next;
  logic           misc_reg,     misc_next;

  logic [7:0]     load_word;
  logic           start_hdr;
  logic           load_pay;
  logic           shift_bit;

  assign load_word = TEST_MODE ? test_cnt_reg : in_q_reg;

  always_ff @(posedge DATA_CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      test_cnt_reg <= '0;
      shift_reg    <= '0;
      in_q_reg     <= '0;
      data_out_reg <= 1'b0;
      sync_reg     <= 1'b0;
      misc_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      word_cnt_reg <= word_cnt_next;
      test_cnt_reg <= test_cnt_next;
      shift_reg    <= shift_next;
      in_q_reg     <= {R1_I, R1_Q, R0_I, R0_Q};
      data_out_reg <= data_out_next;
      sync_reg     <= sync_next;
      misc_reg     <= misc_next;
    end
  end

  // shift_reg holds the word whose MSB is already on DATA_OUT; bit 6 is next.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_cnt_next = word_cnt_reg;
    test_cnt_next = test_cnt_reg;
    shift_next    = shift_reg;
    data_out_next = 1'b0;
    sync_next     = 1'b0;
    misc_next     = 1'b0;
    start_hdr     = 1'b0;
    load_pay      = 1'b0;
    shift_bit     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ENABLE) start_hdr = 1'b1;
      end
      HEADER: begin
        if (bit_cnt_reg == 3'd7) load_pay = 1'b1;
        else                     shift_bit = 1'b1;
      end
      PAYLOAD: begin
        if (bit_cnt_reg != 3'd7) begin
          shift_bit = 1'b1;
        end else if (word_cnt_reg == LAST_WORD) begin
          if (ENABLE) begin
            start_hdr = 1'b1;
          end else begin
            state_next   = IDLE;
            bit_cnt_next = 3'd0;
          end
        end else begin
          word_cnt_next = word_cnt_reg + 1'b1;
          load_pay      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (start_hdr) begin
      state_next    = HEADER;
      bit_cnt_next  = 3'd0;
      word_cnt_next = '0;
      test_cnt_next = 8'd0;
      shift_next    = SYNC_WORD;
      data_out_next = SYNC_WORD[7];
      sync_next     = 1'b1;
      misc_next     = 1'b1;
    end else if (load_pay) begin
      state_next    = PAYLOAD;
      bit_cnt_next  = 3'd0;
      test_cnt_next = test_cnt_reg + 8'd1;
      shift_next    = load_word;
      data_out_next = load_word[7];
      misc_next     = 1'b1;
    end else if (shift_bit) begin
      bit_cnt_next  = bit_cnt_reg + 3'd1;
      shift_next    = {shift_reg[6:0], 1'b0};
      data_out_next = shift_reg[6];
      misc_next     = 1'b1;
    end
  end

  assign DATA_OUT = data_out_reg;
  assign SYNC     = sync_reg;
  assign MISC     = misc_reg;

endmodule

// File: tb/tb_iq_frame_serializer.sv
// Bench for iq_frame_serializer: table-driven single frames, directed corner sequences,
// and randomized traffic compared every cycle against a frame-position reference model.
module tb_iq_frame_serializer;

  localparam int         FS   = 4;
  localparam int         FLEN = 8 * (1 + FS);
  localparam logic [7:0] SW   = 8'hA5;

  logic       DATA_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ENABLE = 1'b0;
  logic       TEST_MODE = 1'b0;
  logic [7:0] pins = 8'h00;
  logic [1:0] R1_I, R1_Q, R0_I, R0_Q;
  logic       DATA_OUT, SYNC, MISC;

  assign {R1_I, R1_Q, R0_I, R0_Q} = pins;

  iq_frame_serializer #(.FRAME_SAMPLES(FS), .SYNC_WORD(SW)) dut (
    .DATA_CLK (DATA_CLK),
    .RST      (RST),
    .R1_I     (R1_I),
    .R1_Q     (R1_Q),
    .R0_I     (R0_I),
    .R0_Q     (R0_Q),
    .ENABLE   (ENABLE),
    .TEST_MODE(TEST_MODE),
    .DATA_OUT (DATA_OUT),
    .SYNC     (SYNC),
    .MISC     (MISC)
  );

  always #5 DATA_CLK = ~DATA_CLK;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge DATA_CLK);
    #1;
  endtask

  // Reference model: tracks frame start edge and derives outputs from the position in the frame.
  logic exp_d = 1'b0, exp_s = 1'b0, exp_m = 1'b0;

  initial begin
    int         n;
    int         start;
    int         pos;
    int         k;
    int         b;
    logic [7:0] pins_prev;
    logic [7:0] cur_word;
    n = 0; start = -1; pins_prev = 8'h00; cur_word = 8'h00;
    forever begin
      @(posedge DATA_CLK);
      n++;
      if (RST) begin
        start = -1;
        exp_d = 1'b0; exp_s = 1'b0; exp_m = 1'b0;
        pins_prev = 8'h00;
      end else begin
        pos = (start >= 0) ? n - start : -1;
        if (pos < 0 && ENABLE) begin
          start = n; pos = 0;
        end else if (pos == FLEN) begin
          if (ENABLE) begin start = n; pos = 0; end
          else begin start = -1; pos = -1; end
        end
        if (pos < 0) begin
          exp_d = 1'b0; exp_s = 1'b0; exp_m = 1'b0;
        end else if (pos < 8) begin
          exp_d = SW[7-pos]; exp_s = (pos == 0); exp_m = 1'b1;
        end else begin
          k = (pos - 8) / 8;
          b = (pos - 8) % 8;
          if (b == 0) cur_word = TEST_MODE ? 8'(k) : pins_prev;
          exp_d = cur_word[7-b]; exp_s = 1'b0; exp_m = 1'b1;
        end
        pins_prev = pins;
      end
    end
  end

  initial begin
    forever begin
      @(negedge DATA_CLK);
      check("model_stream", 32'({DATA_OUT, SYNC, MISC}), RST ? 32'd0 : 32'({exp_d, exp_s, exp_m}));
    end
  end

  typedef struct {
    logic [7:0] pins;
    logic       tm;
    logic [7:0] base;
    logic [7:0] stepv;
  } vec_t;

  task automatic run_frame(input logic [7:0] pv, input logic tmv,
                           input logic [7:0] base, input logic [7:0] stepv, input string name);
    logic [7:0] hdr;
    logic [7:0] words [FS];
    int sync_cnt, misc_cnt, dirty, first_sync;
    hdr = 8'h00; sync_cnt = 0; misc_cnt = 0; dirty = 0; first_sync = 0;
    for (int k = 0; k < FS; k++) words[k] = 8'h00;
    step();
    pins = pv; TEST_MODE = tmv;
    step(); step();
    ENABLE = 1'b1;
    for (int i = 0; i < FLEN + 8; i++) begin
      @(negedge DATA_CLK);
      if (i < 8) hdr[7-i] = DATA_OUT;
      else if (i < FLEN) words[(i-8)/8][7-((i-8)%8)] = DATA_OUT;
      else if (DATA_OUT) dirty++;
      if (SYNC) sync_cnt++;
      if (SYNC && i == 0) first_sync = 1;
      if (MISC) misc_cnt++;
      if (i == 0) begin #1; ENABLE = 1'b0; end
    end
    #1;
    check({name, "_header"}, 32'(hdr), 32'(SW));
    for (int k = 0; k < FS; k++)
      check({name, "_word"}, 32'(words[k]), 32'(8'(base + stepv * k)));
    check({name, "_sync_cnt"}, 32'(sync_cnt), 32'd1);
    check({name, "_sync_first"}, 32'(first_sync), 32'd1);
    check({name, "_misc_cnt"}, 32'(misc_cnt), 32'(FLEN));
    check({name, "_idle_data"}, 32'(dirty), 32'd0);
  endtask

  initial begin
    vec_t vecs [5];
    int   last, syncs, misc_low, misc_cnt;

    vecs[0] = '{pins: 8'hC9, tm: 1'b0, base: 8'hC9, stepv: 8'd0};
    vecs[1] = '{pins: 8'h00, tm: 1'b1, base: 8'h00, stepv: 8'd1};
    vecs[2] = '{pins: 8'hFF, tm: 1'b0, base: 8'hFF, stepv: 8'd0};
    vecs[3] = '{pins: 8'h3C, tm: 1'b1, base: 8'h00, stepv: 8'd1};
    vecs[4] = '{pins: 8'h5A, tm: 1'b0, base: 8'h5A, stepv: 8'd0};

    // Reset state and idle with ENABLE low
    repeat (3) step();
    check("reset_state", 32'({DATA_OUT, SYNC, MISC}), 32'd0);
    RST = 1'b0;
    repeat (3) step();
    check("idle_after_rst", 32'({DATA_OUT, SYNC, MISC}), 32'd0);

    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].pins, vecs[v].tm, vecs[v].base, vecs[v].stepv, "vec");

    // Back-to-back frames with ENABLE held high
    step();
    ENABLE = 1'b1; last = -1; syncs = 0; misc_low = 0;
    for (int i = 0; i < 3 * FLEN; i++) begin
      @(negedge DATA_CLK);
      if (SYNC) begin
        if (last >= 0) check("b2b_spacing", 32'(i - last), 32'(FLEN));
        last = i; syncs++;
      end
      if (!MISC) misc_low++;
    end
    #1; ENABLE = 1'b0;
    check("b2b_syncs", 32'(syncs), 32'd3);
    check("b2b_misc_low", 32'(misc_low), 32'd0);
    repeat (FLEN + 5) step();

    // Early disable during payload word 1
    ENABLE = 1'b1; syncs = 0; misc_cnt = 0;
    for (int i = 0; i < FLEN + 20; i++) begin
      @(negedge DATA_CLK);
      if (SYNC) syncs++;
      if (MISC) misc_cnt++;
      if (i == 19) begin #1; ENABLE = 1'b0; end
    end
    #1;
    check("early_dis_syncs", 32'(syncs), 32'd1);
    check("early_dis_misc", 32'(misc_cnt), 32'(FLEN));

    // Asynchronous reset in payload word 2, then a fresh frame
    pins = 8'hC9; TEST_MODE = 1'b0;
    step();
    ENABLE = 1'b1;
    step();
    ENABLE = 1'b0;
    repeat (26) step();
    check("pre_rst_misc", 32'(MISC), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_async", 32'({DATA_OUT, SYNC, MISC}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold", 32'({DATA_OUT, SYNC, MISC}), 32'd0);
    end
    RST = 1'b0;
    step();
    check("rst_release_idle", 32'({DATA_OUT, SYNC, MISC}), 32'd0);
    run_frame(8'hC9, 1'b0, 8'hC9, 8'd0, "post_rst");

    // Randomized traffic checked by the reference model
    for (int i = 0; i < 3000; i++) begin
      step();
      pins      = 8'($urandom);
      TEST_MODE = 1'($urandom);
      ENABLE    = ($urandom_range(0, 7) == 0);
      RST       = ($urandom_range(0, 299) == 0);
    end
    RST = 1'b0; ENABLE = 1'b0;
    repeat (FLEN + 10) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iq_frame_serializer.md
# iq_frame_serializer

Time-division scheduler that shares the single serial `DATA_OUT` lane between the four 2-bit radio sample channels (R1_I, R1_Q, R0_I, R0_Q). It packs one snapshot of all channels into an 8-bit word and emits fixed-length frames MSB-first at one bit per `DATA_CLK`: an 8-bit sync header followed by `FRAME_SAMPLES` payload words. It sits between the radio sample pins and the `DATA_OUT`/`SYNC`/`MISC` outputs of the radio module top level. A test mode replaces radio data with a counter pattern for link bring-up.

## Interface
- `FRAME_SAMPLES`, default 16: payload words per frame, legal range 1..65535.
- `SYNC_WORD`, default 8'hA5: header byte sent at the start of every frame.
- `DATA_CLK`  in  1  sole clock; all logic on rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `R1_I`, `R1_Q`, `R0_I`, `R0_Q`  in  2 each  radio sample bits, synchronous to `DATA_CLK`.
- `ENABLE`  in  1  level; request framing.
- `TEST_MODE`  in  1  level; 1 selects counter payload.
- `DATA_OUT`  out  1  registered serial bit stream.
- `SYNC`  out  1  registered; high exactly on the header MSB cycle.
- `MISC`  out  1  registered; high on every cycle a frame bit is on `DATA_OUT`.

## Operation
- Pin register `in_q` captures `{R1_I, R1_Q, R0_I, R0_Q}` every edge; bit7 = `R1_I[1]`, bit0 = `R0_Q[0]`.
- States: IDLE, HEADER, PAYLOAD. Counters: `bit_cnt` 3 bits (0 = MSB cycle), `word_cnt` sized for `FRAME_SAMPLES-1`, `test_cnt` 8 bits.
- IDLE: `DATA_OUT`=0, `SYNC`=0, `MISC`=0. `ENABLE`=1 sampled at an edge → that edge enters HEADER with `SYNC_WORD[7]` on `DATA_OUT`, `SYNC`=1, `MISC`=1, `bit_cnt`=0.
- HEADER: bits 7..0 of `SYNC_WORD` over 8 cycles. The edge leaving bit 0 enters PAYLOAD, loads word 0 and drives its MSB.
- PAYLOAD word load: word = `in_q` if `TEST_MODE`=1'b0, else `test_cnt`. `TEST_MODE` is sampled only at load edges and never changes a word mid-shift.
- PAYLOAD progression: each word shifts out over 8 cycles. After word `FRAME_SAMPLES-1` bit 0:
  - If `ENABLE`=1 at that edge, enter HEADER directly with no idle gap.
  - Otherwise enter IDLE.
- `ENABLE` is examined only in IDLE and at frame end. Deasserting it mid-frame never truncates a frame.
- `test_cnt` clears to 0 on entering HEADER and increments by 1 (mod 256) at each payload load.
- `SYNC` is low in all cycles except the header MSB.
- `word_cnt` clears on HEADER entry and increments after each word. No other wrap exists.
- Reset (any time, including mid-frame): state IDLE, all counters 0, `in_q`=0, and `DATA_OUT`, `SYNC`, `MISC` all 0 immediately. After reset release, the next frame always starts with a full header.

## Timing
- Frame length is exactly 8×(1+`FRAME_SAMPLES`) cycles; 136 with defaults.
- Start latency: `ENABLE` high before edge N → header MSB and `SYNC` valid after edge N.
- Sample latency: payload word contents equal the pin values present before edge L−1, where L is the edge at which the word's MSB appears. The two-edge pipeline is `in_q`, then the load.
- Continuous `ENABLE` gives `SYNC` pulses spaced exactly 8×(1+`FRAME_SAMPLES`) cycles, with `MISC` constantly 1.
- The last payload bit is followed by either the next header MSB or, in IDLE, `MISC`=0, `DATA_OUT`=0.
- All outputs are driven directly from flops; there is no combinational path from input to output.

## Test plan
- Reset: assert `RST` asynchronously between edges → `DATA_OUT`/`SYNC`/`MISC` go 0 without a clock edge and stay 0 while `ENABLE`=0.
- Single frame (`FRAME_SAMPLES`=4): pins held at R1_I=11, R1_Q=00, R0_I=10, R0_Q=01, 1-cycle `ENABLE` pulse.
  - `DATA_OUT` = 10100101 then 11001001 ×4.
  - `SYNC` is high for 1 cycle; `MISC` is high for 40 cycles, then idle zeros.
- Back-to-back: `ENABLE` held high, `FRAME_SAMPLES`=4 → `SYNC` every 40 cycles, `MISC` never drops, no gap bits.
- Test mode: `TEST_MODE`=1, `FRAME_SAMPLES`=4 → payloads 8'h00, 8'h01, 8'h02, 8'h03; the next frame restarts at 8'h00.
- Early disable: drop `ENABLE` during payload word 1 → frame completes all 4 words, then IDLE; no second `SYNC`.
- Reset mid-payload: pulse `RST` in word 2, then re-enable → outputs 0 during reset; the next output is a complete header followed by fresh payload.
